ram_burst_master: RTL and testbench

Bus-side master for the 16x8 synchronous single-port RAM. It accepts burst commands from the system, then drives the RAM's `we`/`addr`/`din` port. Write bursts take data from a valid/ready write stream. Read bursts return data on a valid/ready read stream, absorbing the RAM's one-cycle read latency and downstream backpressure with a 3-entry output buffer. It sits between a host or DMA engine and the RAM, and is the only agent driving the RAM port.

---
 rtl/ram_burst_master.sv | 147 ++++++++++++++
 tb/tb_ram_burst_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
// Burst master for a 16x8 synchronous single-port RAM: write bursts come from a
// valid/ready stream, read bursts return through a 3-entry skid FIFO.
module ram_burst_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [ADDR_W-1:0] cmd_len_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam int         DEPTH   = 3;
  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [ADDR_W:0]   ONE_I = 1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;   // beats left minus one (writes / pops)
  logic [ADDR_W:0]   iss_q, iss_d;   // read issues still owed
  logic              done_q, done_d;

  // tag[0]: read issued this cycle; tag[1]: ram_dout holds that read's data
  logic [1:0]        tag;
  logic              tag1_q;
  logic              issue, push, pop;
  logic [2:0]        credit_used;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [1:0]        wp_q, rp_q, fcnt_q;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign credit_used = {1'b0, fcnt_q} + {2'b00, tag1_q};
  assign issue       = (state_q == S_READ) && (iss_q != '0) && (credit_used < 3'd3);
  assign tag         = {tag1_q, issue};
  assign push        = tag[1];
  assign pop         = rd_valid_o && rd_ready_i;

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign wr_ready_o  = (state_q == S_WRITE);
  assign ram_we_o    = (state_q == S_WRITE) && wr_valid_i;
  assign ram_din_o   = (state_q == S_WRITE) ? wr_data_i : '0;
  assign ram_addr_o  = ptr_q;
  assign rd_valid_o  = (fcnt_q != 2'd0);
  assign rd_data_o   = mem_q[rp_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    iss_d   = iss_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_valid_i) begin
        ptr_d   = cmd_addr_i;
        cnt_d   = cmd_len_i;
        iss_d   = {1'b0, cmd_len_i} + ONE_I;
        state_d = cmd_write_i ? S_WRITE : S_READ;
      end
      S_WRITE: if (wr_valid_i) begin
        ptr_d = ptr_q + ONE_A;
        cnt_d = cnt_q - ONE_A;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_READ: begin
        if (issue) begin
          ptr_d = ptr_q + ONE_A;
          iss_d = iss_q - ONE_I;
        end
        if (pop) begin
          cnt_d = cnt_q - ONE_A;
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      iss_q   <= '0;
      done_q  <= 1'b0;
      tag1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      done_q  <= done_d;
      tag1_q  <= tag[0];
    end
  end

  // Output FIFO; credit-limited issue keeps occupancy at or below DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= 2'd0;
      rp_q   <= 2'd0;
      fcnt_q <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= ram_dout_i;
        wp_q        <= inc3(wp_q);
      end
      if (pop) rp_q <= inc3(rp_q);
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 2'd1;
        2'b01:   fcnt_q <= fcnt_q - 2'd1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural 16x8 synchronous RAM.
module tb_ram_burst_master;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       busy, done, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;

  int errors = 0;
  int checks = 0;
  int wcount = 0;
  logic [7:0] mem [16];
  logic [7:0] dbuf [16];
  logic [7:0] ebuf [16];

  ram_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .busy_o(busy), .done_o(done),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_din_o(ram_din),
    .ram_dout_i(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM: read-first, registered output
  initial for (int i = 0; i < 16; i++) mem[i] = 8'hC0 + 8'(i);
  initial ram_dout = 8'h00;
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      wcount <= wcount + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_done"},      32'(done), 0);
    chk({tag, "_wr_ready"},  32'(wr_ready), 0);
    chk({tag, "_rd_valid"},  32'(rd_valid), 0);
    chk({tag, "_rd_data"},   32'(rd_data), 0);
    chk({tag, "_ram_we"},    32'(ram_we), 0);
    chk({tag, "_ram_addr"},  32'(ram_addr), 0);
    chk({tag, "_ram_din"},   32'(ram_din), 0);
  endtask

  // gaps bit i inserts one wr_valid=0 cycle before beat i
  task automatic do_write(input logic [3:0] a, input logic [3:0] l, input logic [15:0] gaps);
    int w0;
    w0 = wcount;
    cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_len = l;
    #1 chk("wr_cmd_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 0;
    for (int i = 0; i <= int'(l); i++) begin
      if (gaps[i]) begin
        wr_valid = 0; wr_data = 8'hEE;
        #1 chk("wr_gap_we", 32'(ram_we), 0);
        tick();
      end
      wr_valid = 1; wr_data = dbuf[i];
      #1;
      chk("wr_ready", 32'(wr_ready), 1);
      chk("wr_we", 32'(ram_we), 1);
      chk("wr_addr", 32'(ram_addr), 32'(4'(a + 4'(i))));
      chk("wr_done_early", 32'(done), 0);
      tick();
    end
    wr_valid = 0;
    #1;
    chk("wr_done", 32'(done), 1);
    chk("wr_idle", 32'(cmd_ready), 1);
    chk("wr_count", 32'(wcount - w0), 32'(int'(l) + 1));
    tick();
    chk("wr_done_clr", 32'(done), 0);
  endtask

  // mode 0: rd_ready always 1; mode 1: low for cycles 2..8, then toggling
  task automatic do_read(input logic [3:0] a, input logic [3:0] l, input int mode);
    int k, first, last;
    logic stall;
    logic [7:0] prev;
    k = 0; first = -1; last = -1; stall = 0; prev = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = a; cmd_len = l;
    #1 chk("rd_cmd_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 0;
    for (int n = 0; n < 120 && k <= int'(l); n++) begin
      if (mode == 0) rd_ready = 1;
      else if (n >= 2 && n <= 8) rd_ready = 0;
      else if (n > 8) rd_ready = n[0];
      else rd_ready = 1;
      #1;
      if (ram_we) chk("rd_we", 32'(ram_we), 0);
      if (rd_valid && first < 0) first = n;
      if (stall) chk("rd_hold", 32'(rd_data), 32'(prev));
      if (rd_valid && rd_ready) begin
        chk("rd_data", 32'(rd_data), 32'(ebuf[k]));
        k++;
        if (k == int'(l) + 1) last = n;
      end
      stall = rd_valid && !rd_ready;
      prev  = rd_data;
      tick();
    end
    rd_ready = 0;
    chk("rd_beats", 32'(k), 32'(int'(l) + 1));
    #1;
    chk("rd_done", 32'(done), 1);
    chk("rd_idle", 32'(cmd_ready), 1);
    chk("rd_empty", 32'(rd_valid), 0);
    if (mode == 0) begin
      chk("rd_first_lat", 32'(first), 2);
      chk("rd_last", 32'(last), 32'(2 + int'(l)));
    end
    tick();
    chk("rd_done_clr", 32'(done), 0);
  endtask

  initial begin
    int pops;
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    // reset
    repeat (3) tick();
    chk_idle_reset("rst_hold");
    rst_n = 1;
    tick();
    chk_idle_reset("rst_rel");
    chk("rst_no_we", 32'(wcount), 0);

    // write 3..6, read back
    dbuf[0] = 8'hA0; dbuf[1] = 8'hA1; dbuf[2] = 8'hA2; dbuf[3] = 8'hA3;
    do_write(4'd3, 4'd3, 16'h0);
    chk("mem3", 32'(mem[3]), 32'hA0);
    chk("mem6", 32'(mem[6]), 32'hA3);
    ebuf[0] = 8'hA0; ebuf[1] = 8'hA1; ebuf[2] = 8'hA2; ebuf[3] = 8'hA3;
    do_read(4'd3, 4'd3, 0);
    chk("addr_hold", 32'(ram_addr), 32'd7);

    // wrapping write and read
    dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33; dbuf[3] = 8'h44;
    do_write(4'd14, 4'd3, 16'h0);
    chk("mem14", 32'(mem[14]), 32'h11);
    chk("mem15", 32'(mem[15]), 32'h22);
    chk("mem0",  32'(mem[0]),  32'h33);
    chk("mem1",  32'(mem[1]),  32'h44);
    ebuf[0] = 8'h11; ebuf[1] = 8'h22; ebuf[2] = 8'h33; ebuf[3] = 8'h44;
    do_read(4'd14, 4'd3, 0);

    // 5-beat write at 8 with stalls before beats 1, 2 and 4
    dbuf[0] = 8'h51; dbuf[1] = 8'h52; dbuf[2] = 8'h53; dbuf[3] = 8'h54; dbuf[4] = 8'h55;
    do_write(4'd8, 4'd4, 16'b10110);
    chk("mem8",  32'(mem[8]),  32'h51);
    chk("mem12", 32'(mem[12]), 32'h55);
    chk("mem13", 32'(mem[13]), 32'hCD);

    // 16-beat read with backpressure
    ebuf[0]  = 8'h33; ebuf[1]  = 8'h44; ebuf[2]  = 8'hC2; ebuf[3]  = 8'hA0;
    ebuf[4]  = 8'hA1; ebuf[5]  = 8'hA2; ebuf[6]  = 8'hA3; ebuf[7]  = 8'hC7;
    ebuf[8]  = 8'h51; ebuf[9]  = 8'h52; ebuf[10] = 8'h53; ebuf[11] = 8'h54;
    ebuf[12] = 8'h55; ebuf[13] = 8'hCD; ebuf[14] = 8'h11; ebuf[15] = 8'h22;
    do_read(4'd0, 4'd15, 1);

    // reset after beat 2 of an 8-beat read
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd3; cmd_len = 4'd7;
    tick();
    cmd_valid = 0; rd_ready = 1;
    pops = 0;
    for (int n = 0; n < 20 && pops < 2; n++) begin
      #1;
      if (rd_valid) pops++;
      tick();
    end
    chk("mr_pops", 32'(pops), 2);
    chk("mr_busy", 32'(busy), 1);
    rst_n = 0;
    #1;
    chk_idle_reset("mr_rst");
    tick();
    rst_n = 1; rd_ready = 0;
    tick();
    chk_idle_reset("mr_rel");
    ebuf[0] = 8'hA0; ebuf[1] = 8'hA1; ebuf[2] = 8'hA2; ebuf[3] = 8'hA3;
    do_read(4'd3, 4'd3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
